// File: rtl/mlp_result_stream_tx.sv
// -----------------------------------------------------------------------------
// mlp_result_stream_tx
//
// This block transmits result rows from the PE array and accumulators to the
// top-level result port.
//
// It accepts a complete result row (ROW_ELEMS signed elements of ELEM_W bits)
// and places it in one of two ping-pong row buffers. It then sends each
// buffered row as ROW_ELEMS/2 beats. Each beat carries two packed elements.
// The block also counts rows within a frame of FRAME_ROWS rows and marks the
// final beat of each frame.
//
// Handshake (input side): a row transfers on a rising edge where
// row_valid_i && row_ready_o. row_ready_o depends only on registered
// occupancy. It never looks at row_valid_i. While row_ready_o is low, the
// source must hold its row unchanged. The output side has no backpressure:
// every cycle with result_valid_o high is one beat.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   row_valid_i      a row is offered on row_data_i
//   row_data_i       row elements; element e is at [e*ELEM_W +: ELEM_W]
//   row_ready_o      a row buffer is free (low while in reset)
//   result_valid_o   beat valid
//   result_payload_o {elem[2k+1], elem[2k]} for beat k; zero when not valid
//   result_last_o    final beat of row FRAME_ROWS-1
//   frame_busy_o     from the first accepted row of a frame through its last beat
// -----------------------------------------------------------------------------
module mlp_result_stream_tx #(
    parameter int ELEM_W     = 16,
    parameter int ROW_ELEMS  = 16,
    parameter int FRAME_ROWS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          row_valid_i,
    input  logic [ROW_ELEMS*ELEM_W-1:0]   row_data_i,
    output logic                          row_ready_o,
    output logic                          result_valid_o,
    output logic [2*ELEM_W-1:0]           result_payload_o,
    output logic                          result_last_o,
    output logic                          frame_busy_o
);

    localparam int ROW_W  = ROW_ELEMS * ELEM_W;
    localparam int PAY_W  = 2 * ELEM_W;
    localparam int BEATS  = ROW_ELEMS / 2;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROWC_W = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ROWC_W-1:0] LAST_ROW  = ROWC_W'(FRAME_ROWS - 1);

    // SEND means the head buffer holds a row that still has beats to drive.
    // The FSM is in SEND exactly when occupancy is non-zero.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [ROW_W-1:0]   buf0_q,     buf0_d;
    logic [ROW_W-1:0]   buf1_q,     buf1_d;
    logic               wr_sel_q,   wr_sel_d;
    logic               rd_sel_q,   rd_sel_d;
    logic [1:0]         count_q,    count_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ROWC_W-1:0]  row_cnt_q,  row_cnt_d;
    logic               rdy_en_q,   rdy_en_d;
    logic               valid_q,    valid_d;
    logic [PAY_W-1:0]   payload_q,  payload_d;
    logic               last_q,     last_d;
    logic               busy_q,     busy_d;

    logic               accept;
    logic               release_row;
    logic [ROW_W-1:0]   head_row;

    // rdy_en_q holds ready low while rst is high. It releases ready on the
    // first clock edge after rst is deasserted.
    assign row_ready_o      = rdy_en_q && (count_q != 2'd2);
    assign result_valid_o   = valid_q;
    assign result_payload_o = payload_q;
    assign result_last_o    = last_q;
    assign frame_busy_o     = busy_q;

    always_comb begin
        state_d    = state_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q;
        row_cnt_d  = row_cnt_q;
        rdy_en_d   = 1'b1;
        valid_d    = 1'b0;
        payload_d  = '0;
        last_d     = 1'b0;
        busy_d     = busy_q;

        accept      = row_valid_i && row_ready_o;
        head_row    = rd_sel_q ? buf1_q : buf0_q;
        release_row = (state_q == SEND) && (beat_cnt_q == LAST_BEAT);

        if (accept) begin
            if (wr_sel_q) begin
                buf1_d = row_data_i;
            end else begin
                buf0_d = row_data_i;
            end
            wr_sel_d = ~wr_sel_q;
        end

        if (state_q == SEND) begin
            valid_d   = 1'b1;
            payload_d = PAY_W'(head_row >> (int'(beat_cnt_q) * PAY_W));
            last_d    = (beat_cnt_q == LAST_BEAT) && (row_cnt_q == LAST_ROW);
            if (release_row) begin
                // The head buffer is freed on the same edge that drives its
                // last beat. If the other buffer holds a row, that row's
                // beat 0 follows on the next edge with no gap.
                beat_cnt_d = '0;
                rd_sel_d   = ~rd_sel_q;
                row_cnt_d  = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        case ({accept, release_row})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        state_d = (count_d != 2'd0) ? SEND : IDLE;

        // busy drops one edge after the frame's last beat is on the outputs.
        // It stays high if a row of the next frame is already buffered or is
        // being accepted on that edge.
        if (last_q) begin
            busy_d = accept || (count_q != 2'd0);
        end else if (accept) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            buf0_q     <= '0;
            buf1_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            count_q    <= 2'd0;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            rdy_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            payload_q  <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
            rdy_en_q   <= rdy_en_d;
            valid_q    <= valid_d;
            payload_q  <= payload_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
        end
    end

endmodule
